alu_op_issue: RTL and testbench

Sequencing front end for the 16-input ALU result multiplexer. Accepts one MIPS instruction (primary opcode and funct fields) per valid/ready handshake and decodes it to the 4-bit ALU select. Holds that select stable for the single-cycle or multi-cycle execution window, then captures the selected 33-bit mux output into a result register offered downstream under valid/ready. It drives the mux select and consumes the mux output.

---
 rtl/alu_op_issue.sv | 144 ++++++++++++++
 tb/tb_alu_op_issue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// Issue sequencer for the ALU result mux: decodes a MIPS op/funct to a mux select,
// holds it through the execute window, then offers the captured result. Option: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_op_issue #(
  parameter int WIDTH        = 32,
  parameter int MULTI_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_field,
  input  logic [5:0]       funct,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH:0]   mux_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid may not depend on ready, and offered data stays stable until the transfer edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MC   = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'hF;
  localparam logic [3:0] SEL_MULT = 4'd10;
  localparam logic [3:0] SEL_DIV  = 4'd11;
  localparam logic [3:0] MC_LOAD  = 4'(MULTI_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] dec_sel;
  logic [3:0] acc_sel;

  // SEL_NONE is never a real select, so it doubles as the "undecodable" marker.
  always_comb begin
    dec_sel = SEL_NONE;
    case (op_field)
      6'h00: begin
        case (funct)
          6'h20:   dec_sel = 4'd0;
          6'h22:   dec_sel = 4'd1;
          6'h24:   dec_sel = 4'd2;
          6'h25:   dec_sel = 4'd3;
          6'h26:   dec_sel = 4'd4;
          6'h27:   dec_sel = 4'd5;
          6'h2A:   dec_sel = 4'd6;
          6'h00:   dec_sel = 4'd7;
          6'h02:   dec_sel = 4'd8;
          6'h03:   dec_sel = 4'd9;
          6'h18:   dec_sel = SEL_MULT;
          6'h1A:   dec_sel = SEL_DIV;
          default: dec_sel = SEL_NONE;
        endcase
      end
      6'h08:   dec_sel = 4'd0;
      6'h0C:   dec_sel = 4'd2;
      6'h0D:   dec_sel = 4'd3;
      6'h0E:   dec_sel = 4'd4;
      6'h0A:   dec_sel = 4'd6;
      6'h0F:   dec_sel = 4'd12;
      default: dec_sel = SEL_NONE;
    endcase
  end

  // Undecodable ops fall back to add when they are not trapped.
  assign acc_sel   = (dec_sel == SEL_NONE) ? 4'd0 : dec_sel;
  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      alu_sel   <= SEL_NONE;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            if (dec_sel == SEL_NONE) begin
              illegal_q <= 1'b1;
            end else
`endif
            begin
              alu_sel <= acc_sel;
              if (acc_sel == SEL_MULT || acc_sel == SEL_DIV) begin
                cnt   <= MC_LOAD;
                state <= MC;
              end else begin
                state <= EXEC;
              end
            end
          end
        end
        EXEC: begin
          res_data  <= mux_result;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        MC: begin
          if (cnt == 4'd0) begin
            res_data  <= mux_result;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            alu_sel   <= SEL_NONE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode table sweep, latency, backpressure,
// reset during a multi-cycle op and illegal-op handling.
module tb_alu_op_issue;

  localparam int W  = 32;
  localparam int MC = 4;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   op_field;
  logic [5:0]   funct;
  logic [3:0]   alu_sel;
  logic [W:0]   mux_result;
  logic         res_valid;
  logic         res_ready;
  logic [W:0]   res_data;
  logic         illegal;
  logic [1:0]   state_dbg;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] sel;
    logic       multi;
  } vec_t;

  vec_t vecs[18];

  alu_op_issue #(.WIDTH(W), .MULTI_CYCLES(MC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_field   (op_field),
    .funct      (funct),
    .alu_sel    (alu_sel),
    .mux_result (mux_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] make_val(input logic [31:0] seed, input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {kk[0], seed + kk * 32'h0101_0101};
  endfunction

  // Drives one op, measures edges from accept to res_valid, optionally stalls the
  // result for hold_cycles with spurious in_valid pulses, then drains it.
  task automatic run_op(input string name, input logic [5:0] op, input logic [5:0] fn,
                        input logic [3:0] exp_sel, input int lat, input logic [31:0] seed,
                        input int hold_cycles);
    int k;
    logic [W:0] exp_data;
    @(negedge clk);
    in_valid   = 1'b1;
    op_field   = op;
    funct      = fn;
    res_ready  = 1'b0;
    mux_result = make_val(seed, 77);
    check({name, " in_ready idle"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " sel"}, alu_sel, exp_sel);
    k = 0;
    while (!res_valid && k < 40) begin
      mux_result = make_val(seed, k);
      @(negedge clk);
      k++;
    end
    exp_data = make_val(seed, lat - 1);
    check({name, " latency"}, k, lat);
    check({name, " res_data"}, res_data, exp_data);
    check({name, " sel held"}, alu_sel, exp_sel);
    check({name, " illegal"}, illegal, 1'b0);
    for (int h = 0; h < hold_cycles; h++) begin
      in_valid   = h[0];
      op_field   = 6'h00;
      funct      = 6'h22;
      mux_result = make_val(~seed, h);
      @(negedge clk);
      check({name, " hold valid"}, res_valid, 1'b1);
      check({name, " hold data"}, res_data, exp_data);
      check({name, " hold in_ready"}, in_ready, 1'b0);
      check({name, " hold sel"}, alu_sel, exp_sel);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, " drained valid"}, res_valid, 1'b0);
    check({name, " drained in_ready"}, in_ready, 1'b1);
    check({name, " drained sel"}, alu_sel, 4'hF);
    check({name, " data kept"}, res_data, exp_data);
  endtask

  initial begin
    int lat;
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    op_field   = 6'h00;
    funct      = 6'h00;
    res_ready  = 1'b0;
    mux_result = '0;

    vecs[0]  = '{op: 6'h00, fn: 6'h20, sel: 4'd0,  multi: 1'b0};
    vecs[1]  = '{op: 6'h00, fn: 6'h22, sel: 4'd1,  multi: 1'b0};
    vecs[2]  = '{op: 6'h00, fn: 6'h24, sel: 4'd2,  multi: 1'b0};
    vecs[3]  = '{op: 6'h00, fn: 6'h25, sel: 4'd3,  multi: 1'b0};
    vecs[4]  = '{op: 6'h00, fn: 6'h26, sel: 4'd4,  multi: 1'b0};
    vecs[5]  = '{op: 6'h00, fn: 6'h27, sel: 4'd5,  multi: 1'b0};
    vecs[6]  = '{op: 6'h00, fn: 6'h2A, sel: 4'd6,  multi: 1'b0};
    vecs[7]  = '{op: 6'h00, fn: 6'h00, sel: 4'd7,  multi: 1'b0};
    vecs[8]  = '{op: 6'h00, fn: 6'h02, sel: 4'd8,  multi: 1'b0};
    vecs[9]  = '{op: 6'h00, fn: 6'h03, sel: 4'd9,  multi: 1'b0};
    vecs[10] = '{op: 6'h00, fn: 6'h18, sel: 4'd10, multi: 1'b1};
    vecs[11] = '{op: 6'h00, fn: 6'h1A, sel: 4'd11, multi: 1'b1};
    vecs[12] = '{op: 6'h08, fn: 6'h15, sel: 4'd0,  multi: 1'b0};
    vecs[13] = '{op: 6'h0C, fn: 6'h2B, sel: 4'd2,  multi: 1'b0};
    vecs[14] = '{op: 6'h0D, fn: 6'h00, sel: 4'd3,  multi: 1'b0};
    vecs[15] = '{op: 6'h0E, fn: 6'h3F, sel: 4'd4,  multi: 1'b0};
    vecs[16] = '{op: 6'h0A, fn: 6'h18, sel: 4'd6,  multi: 1'b0};
    vecs[17] = '{op: 6'h0F, fn: 6'h20, sel: 4'd12, multi: 1'b0};

    // reset values
    #12;
    check("rst alu_sel", alu_sel, 4'hF);
    check("rst res_valid", res_valid, 1'b0);
    check("rst res_data", res_data, '0);
    check("rst illegal", illegal, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst in_ready", in_ready, 1'b1);

    // decode sweep
    for (int i = 0; i < 18; i++) begin
      lat = vecs[i].multi ? MC : 1;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].sel, lat,
             32'h1000_0000 + 32'(i) * 32'h0013_1111, 0);
    end

    // backpressure on ori
    run_op("ori stall", 6'h0D, 6'h00, 4'd3, 1, 32'hCAFE_0001, 6);

    // add with res_ready high, then an immediate second op (sub)
    @(negedge clk);
    in_valid   = 1'b1;
    op_field   = 6'h00;
    funct      = 6'h20;
    res_ready  = 1'b1;
    mux_result = 33'h0_0000_0005;
    @(negedge clk);
    check("tp sel add", alu_sel, 4'd0);
    check("tp busy", in_ready, 1'b0);
    check("tp not yet valid", res_valid, 1'b0);
    @(negedge clk);
    check("tp valid", res_valid, 1'b1);
    check("tp data", res_data, 33'h0_0000_0005);
    funct      = 6'h22;
    mux_result = 33'h1_0000_0009;
    @(negedge clk);
    check("tp back idle", in_ready, 1'b1);
    check("tp valid dropped", res_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("tp second sel", alu_sel, 4'd1);
    check("tp second busy", in_ready, 1'b0);
    @(negedge clk);
    check("tp second data", res_data, 33'h1_0000_0009);
    @(negedge clk);
    res_ready = 1'b0;
    check("tp second drained", in_ready, 1'b1);

    // reset while a mult is in its multi-cycle window
    @(negedge clk);
    in_valid = 1'b1;
    funct    = 6'h18;
    mux_result = 33'h1_2345_6789;
    @(negedge clk);
    in_valid = 1'b0;
    check("mc rst sel before", alu_sel, 4'd10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mc rst sel", alu_sel, 4'hF);
    check("mc rst valid", res_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mc rst in_ready", in_ready, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mc rst no result", res_valid, 1'b0);
      check("mc rst no illegal", illegal, 1'b0);
    end
    check("mc rst data", res_data, '0);

    // illegal op 0x3F
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    @(negedge clk);
    in_valid = 1'b1;
    op_field = 6'h3F;
    funct    = 6'h20;
    check("trap in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("trap pulse", illegal, 1'b1);
    check("trap sel", alu_sel, 4'hF);
    check("trap in_ready after", in_ready, 1'b1);
    @(negedge clk);
    check("trap pulse ends", illegal, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("trap no result", res_valid, 1'b0);
    end
`else
    run_op("illegal as add", 6'h3F, 6'h20, 4'd0, 1, 32'h0BAD_F00D, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
